kbd_event_queue: RTL and testbench

Buffers decoded keyboard events for the game/control logic and sits directly downstream of the PS/2 keyboard decoder. Each `key_valid` pulse from the decoder becomes one press/release event word, containing the 9-bit key code, in a first-word-fall-through FIFO. The consumer drains the FIFO with a simple pop handshake. An optional typematic generator re-issues press events for a held key.

---
 rtl/kbd_pkg.sv | 23 ++
 rtl/kbd_event_fifo.sv | 59 +++++
 rtl/kbd_event_queue.sv | 117 +++++++++++
 tb/tb_kbd_event_queue.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/kbd_pkg.sv
// Shared definitions for the keyboard event queue: event word layout and
// typematic repeat state encoding.
package kbd_pkg;

  localparam int EVT_W      = 11;
  localparam int REPEAT_BIT = 10;
  localparam int PRESS_BIT  = 9;
  localparam int CODE_MSB   = 8;

  typedef logic [EVT_W-1:0] kbd_evt_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } rpt_state_t;

  function automatic kbd_evt_t mk_evt(input logic rpt, input logic press,
                                      input logic [CODE_MSB:0] code);
    return {rpt, press, code};
  endfunction

endpackage

// File: rtl/kbd_event_fifo.sv
// Generic first-word-fall-through FIFO with registered count/full/empty and a
// sticky overflow flag for pushes that find the FIFO full.
module kbd_event_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic [W-1:0]             rd_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("kbd_event_fifo: DEPTH must be a power of two >= 2");
  end

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr, rd_ptr, wr_nxt, rd_nxt;
  logic         push_ok, pop_ok;

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign wr_nxt  = wr_ptr + {{AW{1'b0}}, push_ok};
  assign rd_nxt  = rd_ptr + {{AW{1'b0}}, pop_ok};

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      empty    <= 1'b1;
      full     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      wr_ptr <= wr_nxt;
      rd_ptr <= rd_nxt;
      count  <= wr_nxt - rd_nxt;
      empty  <= (wr_nxt == rd_nxt);
      full   <= (wr_nxt[AW] != rd_nxt[AW]) && (wr_nxt[AW-1:0] == rd_nxt[AW-1:0]);
      if (push && !push_ok) overflow <= 1'b1;
    end
  end

  assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/kbd_event_queue.sv
// Keyboard event queue: turns decoder strobes into {repeat, press, code} words
// in a FWFT FIFO. Define KBD_AUTO_REPEAT_EN to add the typematic generator.
module kbd_event_queue
  import kbd_pkg::*;
#(
  parameter int DEPTH         = 8,
  parameter int REPEAT_DELAY  = 50_000_000,
  parameter int REPEAT_PERIOD = 10_000_000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [511:0]             key_down,
  input  logic [CODE_MSB:0]        last_change,
  input  logic                     key_valid,
  input  logic                     rd_en,
  output logic [EVT_W-1:0]         rd_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_repeat
    $error("kbd_event_queue: REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
  end

  logic     evt_press;
  kbd_evt_t key_evt, rpt_evt, push_data;
  logic     rpt_push, push;

  // The decoder updates key_down in the strobe cycle, so this read is current.
  assign evt_press = key_down[last_change];
  assign key_evt   = mk_evt(1'b0, evt_press, last_change);

`ifdef KBD_AUTO_REPEAT_EN
  rpt_state_t        state_q, state_d;
  logic [CODE_MSB:0] held_q, held_d;
  logic [31:0]       cnt_q, cnt_d;
  logic              rpt_fire;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      held_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      held_q  <= held_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    held_d   = held_q;
    cnt_d    = cnt_q + 32'd1;
    rpt_fire = 1'b0;
    case (state_q)
      IDLE: cnt_d = '0;
      DELAY: begin
        if (cnt_q == 32'(REPEAT_DELAY - 1)) begin
          rpt_fire = 1'b1;
          cnt_d    = '0;
          state_d  = REPEAT;
        end
      end
      REPEAT: begin
        if (cnt_q == 32'(REPEAT_PERIOD - 1)) begin
          rpt_fire = 1'b1;
          cnt_d    = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    // Decoder events override the timer; releases of other keys leave it running.
    if (key_valid) begin
      if (evt_press) begin
        held_d  = last_change;
        cnt_d   = '0;
        state_d = DELAY;
      end else if (last_change == held_q) begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    end
  end

  assign rpt_push = rpt_fire && !key_valid;
  assign rpt_evt  = mk_evt(1'b1, 1'b1, held_q);
`else
  assign rpt_push = 1'b0;
  assign rpt_evt  = '0;
`endif

  assign push      = key_valid || rpt_push;
  assign push_data = key_valid ? key_evt : rpt_evt;

  kbd_event_fifo #(
    .W     (EVT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (rd_en),
    .rd_data   (rd_data),
    .empty     (empty),
    .full      (full),
    .count     (count),
    .overflow  (overflow)
  );

endmodule

// File: tb/tb_kbd_event_queue.sv
// Scoreboard bench for kbd_event_queue: stimulus pushes expected words into a
// queue; a negedge monitor compares flags, head word and pops on rd_en.
module tb_kbd_event_queue;

  localparam int DEPTH = 4;
  localparam int DLY   = 20;
  localparam int PER   = 5;
  localparam int CW    = $clog2(DEPTH) + 1;
`ifdef KBD_AUTO_REPEAT_EN
  localparam bit RPT = 1'b1;
`else
  localparam bit RPT = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [511:0]   key_down = '0;
  logic [8:0]     last_change = '0;
  logic           key_valid = 1'b0;
  logic           rd_en = 1'b0;
  logic [10:0]    rd_data;
  logic           empty, full, overflow;
  logic [CW-1:0]  count;

  kbd_event_queue #(
    .DEPTH         (DEPTH),
    .REPEAT_DELAY  (DLY),
    .REPEAT_PERIOD (PER)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .key_down    (key_down),
    .last_change (last_change),
    .key_valid   (key_valid),
    .rd_en       (rd_en),
    .rd_data     (rd_data),
    .empty       (empty),
    .full        (full),
    .count       (count),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [10:0] exp_q[$];
  int          mcount = 0;
  bit          movf = 1'b0;
  int          cur_cnt = 0;
  bit          cur_ovf = 1'b0;
  bit          act = 1'b0;
  logic [8:0]  held = '0;
  int          next_fire = 0;
  int          cyc = 0;
  bit          go = 1'b0;
  int          nchk = 0;
  int          nerr = 0;

  task automatic chk(input string nm, input logic [31:0] act_v, input logic [31:0] exp_v);
    nchk++;
    if (act_v !== exp_v) begin
      nerr++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act_v, exp_v);
    end
  endtask

  always @(negedge clk) begin
    if (go) begin
      chk("count", 32'(count), 32'(cur_cnt));
      chk("empty", 32'(empty), 32'(cur_cnt == 0));
      chk("full", 32'(full), 32'(cur_cnt == DEPTH));
      chk("overflow", 32'(overflow), 32'(cur_ovf));
      if (cur_cnt == 0) chk("rd_data_empty", 32'(rd_data), 32'd0);
      else begin
        chk("head", 32'(rd_data), 32'(exp_q[0]));
        if (rd_en) void'(exp_q.pop_front());
      end
    end
  end

  // One clock cycle of stimulus; called just after a rising edge.
  task automatic step(input bit r, input bit kv, input logic [8:0] code,
                      input bit prs, input bit rd);
    bit          fire, push, pop_ok;
    logic [10:0] word;
    cyc++;
    rst = r;
    key_valid = kv && !r;
    rd_en = rd && !r;
    if (kv && !r) begin
      key_down[code] = prs;
      last_change = code;
    end
    if (r) begin
      exp_q.delete();
      mcount = 0; movf = 1'b0; act = 1'b0; held = '0;
      cur_cnt = 0; cur_ovf = 1'b0;
    end else begin
      cur_cnt = mcount;
      cur_ovf = movf;
      fire = RPT && act && (cyc == next_fire);
      push = 1'b0;
      word = '0;
      if (kv) begin
        push = 1'b1;
        word = {1'b0, prs, code};
        if (prs) begin
          held = code; act = 1'b1; next_fire = cyc + DLY;
        end else if (code == held) act = 1'b0;
        else if (fire) next_fire = cyc + PER;
      end else if (fire) begin
        push = 1'b1;
        word = {2'b11, held};
        next_fire = cyc + PER;
      end
      pop_ok = rd && (mcount > 0);
      if (push) begin
        if (mcount < DEPTH || pop_ok) begin
          exp_q.push_back(word);
          mcount++;
        end else movf = 1'b1;
      end
      if (pop_ok) mcount--;
    end
    go = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input bit rd);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 9'h0, 1'b0, rd);
  endtask

  initial begin
    logic [8:0] codes [6];
    codes[0] = 9'h01C; codes[1] = 9'h023; codes[2] = 9'h174;
    codes[3] = 9'h1FF; codes[4] = 9'h000; codes[5] = 9'h033;
    @(posedge clk);
    #1;
    step(1'b1, 0, 9'h0, 0, 0);
    step(1'b1, 0, 9'h0, 0, 0);
    idle(2, 1'b1);
    // Press/release of A, then extended key
    step(1'b0, 1, 9'h01C, 1, 0);
    idle(1, 1'b0);
    step(1'b0, 1, 9'h01C, 0, 0);
    idle(3, 1'b1);
    step(1'b0, 1, 9'h174, 1, 0);
    step(1'b0, 0, 9'h0, 0, 1);
    step(1'b0, 1, 9'h174, 0, 0);
    idle(3, 1'b1);
    // Overflow with five pushes, then push+pop while full
    step(1'b0, 1, 9'h010, 0, 0);
    step(1'b0, 1, 9'h011, 0, 0);
    step(1'b0, 1, 9'h012, 0, 0);
    step(1'b0, 1, 9'h013, 0, 0);
    step(1'b0, 1, 9'h014, 0, 0);
    step(1'b0, 1, 9'h015, 0, 1);
    idle(6, 1'b1);
    step(1'b1, 0, 9'h0, 0, 0);
    // Typematic: hold A, release, hold A then switch to 0x023
    step(1'b0, 1, 9'h01C, 1, 1);
    idle(35, 1'b1);
    step(1'b0, 1, 9'h01C, 0, 1);
    idle(30, 1'b1);
    step(1'b0, 1, 9'h01C, 1, 1);
    idle(27, 1'b1);
    step(1'b0, 1, 9'h023, 1, 1);
    idle(30, 1'b1);
    step(1'b0, 1, 9'h023, 0, 1);
    idle(4, 1'b1);
    // Reset with entries queued and the repeat timer running
    step(1'b0, 1, 9'h01C, 1, 0);
    step(1'b0, 1, 9'h033, 0, 0);
    step(1'b0, 1, 9'h044, 0, 0);
    idle(22, 1'b0);
    step(1'b1, 0, 9'h0, 0, 0);
    idle(40, 1'b0);
    // Randomized traffic: dense and sparse phases, occasional resets
    for (int i = 0; i < 1600; i++) begin
      bit dense;
      bit kv;
      dense = ((i / 200) % 2) == 0;
      kv = dense ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 399) == 0) step(1'b1, 0, 9'h0, 0, 0);
      else step(1'b0, kv, codes[$urandom_range(0, 5)], 1'($urandom_range(0, 1)),
                dense ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 2) == 0));
    end
    idle(10, 1'b1);
    go = 1'b0;
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
